beat_sequencer: RTL and testbench
=================================

# beat_sequencer

Sequences the metronome beat stream into bars: counts beats within a configurable bar length, gates clicks with a start/stop control, and drives an accented/normal click envelope for the audio stage. Sits between the metronome core (consumes its 1-cycle `o_trigger`) and the tone/LED output logic. Beats-per-bar is set from two debounced push-button pulses.

## Interface
- `MAX_BEATS`, default 16: maximum beats per bar; minimum is 1.
- `ACCENT_CYCLES`, default 5_000_000: click length on beat 0, in clocks (100 ms at 50 MHz).
- `NORMAL_CYCLES`, default 2_500_000: click length on beats 1..N-1, in clocks.
- `BAR_W`, default 16: bar counter width.
- Derived: `IDX_W = $clog2(MAX_BEATS+1)`, `TMR_W = $clog2(max(ACCENT_CYCLES, NORMAL_CYCLES)+1)`.

Ports:
- `i_clk`  in  1: clock.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_trigger`  in  1: 1-cycle beat pulse from the metronome core.
- `i_btn_start_stop`  in  1: 1-cycle debounced pulse that toggles run state.
- `i_btn_beats_up`  in  1: 1-cycle pulse, beats-per-bar +1.
- `i_btn_beats_down`  in  1: 1-cycle pulse, beats-per-bar −1.
- `o_beats_per_bar`  out  IDX_W: current bar length.
- `o_beat_index`  out  IDX_W: current beat, 0..beats_per_bar−1.
- `o_bar_count`  out  BAR_W: completed-bar counter.
- `o_running`  out  1: high in ARMED or RUNNING.
- `o_click`  out  1: click envelope, a level.
- `o_accent`  out  1: high while the current click is an accent click.
- `o_bar_start`  out  1: 1-cycle pulse when beat 0 is issued.

## Operation
- FSM states: STOPPED (reset), ARMED, RUNNING.
  - STOPPED, on start_stop → ARMED.
  - ARMED, on i_trigger → RUNNING. Issues beat 0.
  - ARMED or RUNNING, on start_stop → STOPPED.
- Entering STOPPED immediately does the following:
  - clears `o_click`, `o_accent` and the click timer;
  - sets `o_beat_index` = 0;
  - holds `o_bar_count`. It clears only on reset.
- In STOPPED, i_trigger is ignored.
- Beat advance in RUNNING, on each i_trigger:
  - `next = (idx+1 >= beats_per_bar) ? 0 : idx+1`.
  - When next == 0: assert `o_bar_start`, and `o_bar_count` += 1 (wraps 2^BAR_W−1 → 0).
- Issuing a beat does the following:
  - loads the click timer with ACCENT_CYCLES if the beat is 0, otherwise NORMAL_CYCLES;
  - sets `o_accent` accordingly;
  - a beat arriving while a click is still active retriggers it: the timer is reloaded and `o_accent` updated.
- Beats-per-bar:
  - reset value 4;
  - up saturates at MAX_BEATS, down saturates at 1;
  - up and down in the same cycle: no change.
- Shrinking the bar below `o_beat_index+1` while running: the index is kept. The next trigger wraps to 0 under the `>=` rule.
- Simultaneous start_stop and i_trigger: start_stop wins.
  - From STOPPED → ARMED; that trigger is not consumed.
  - From ARMED or RUNNING → STOPPED; no click is issued.
- Reset values: all outputs 0, except `o_beats_per_bar` = 4. State = STOPPED.

## Timing
- Beat latency: i_trigger sampled at edge N, so `o_click`, `o_accent`, `o_beat_index` and `o_bar_start` update at edge N+1. This is 1 cycle, registered outputs only.
- Click length: `o_click` is high for exactly L cycles, from N+1 through N+L. L is ACCENT_CYCLES or NORMAL_CYCLES.
- `o_bar_start` is high for one cycle only (N+1). `o_bar_count` updates at N+1.
- Start/stop: pulse at edge N, so `o_running` and the click clear take effect at N+1.
- Button to `o_beats_per_bar`: 1 cycle.
- Reset mid-click: outputs go to their reset values asynchronously. The first beat needs a new start_stop.

## Structure
- `metronome_pkg` holds:
  - the state enum `seq_state_t` (STOPPED, ARMED, RUNNING);
  - default constants `DEF_BEATS_PER_BAR` = 4, `DEF_ACCENT_CYCLES`, `DEF_NORMAL_CYCLES`.
- Sub-module `click_timer`:
  - inputs: load, clear, load value;
  - outputs: active level;
  - down-counter of TMR_W bits.
- Bar/beat counting and the FSM live in `beat_sequencer`.

## Test plan
Use ACCENT_CYCLES=8 and NORMAL_CYCLES=4 to keep simulation short.
- Reset, then start_stop, then 5 triggers 20 cycles apart:
  - `o_beat_index` = 0,1,2,3,0;
  - `o_click` widths 8,4,4,4,8;
  - `o_bar_start` pulses on triggers 1 and 5;
  - `o_bar_count` ends at 2.
- Triggers while STOPPED: no `o_click`, `o_beat_index` stays 0.
- start_stop and a trigger in the same cycle while RUNNING:
  - `o_running` = 0 next cycle, no click;
  - an in-flight click is cut immediately.
- Beats-per-bar limits:
  - 20 up pulses saturate at 16; 20 down pulses saturate at 1;
  - up and down together leave the value unchanged;
  - with bpb=1, every trigger gives an accent and an `o_bar_start`.
- At index 5 with bpb=8, set bpb to 3: the next trigger gives index 0, an accent, and `o_bar_start`.
- Retrigger:
  - a trigger 2 cycles into a normal click reloads the timer, so the click lasts 2+L cycles in total;
  - assert i_reset mid-click: all outputs are 0 and bpb is 4 without waiting for a clock edge.

Source files
------------

// File: rtl/metronome_pkg.sv
// Shared types and defaults for the metronome beat path.
// Holds the sequencer state encoding and the default bar/click constants.
package metronome_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } seq_state_t;

  localparam int DEF_BEATS_PER_BAR = 4;
  localparam int DEF_MAX_BEATS     = 16;
  localparam int DEF_ACCENT_CYCLES = 5_000_000;
  localparam int DEF_NORMAL_CYCLES = 2_500_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/click_timer.sv
// Click envelope down-counter: active is high for exactly load_val cycles after a load.
// Latency: load seen at edge N gives active from N+1; clear wins over load; no backpressure.
module click_timer #(
  parameter int TMR_W = 23
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             load,
  input  logic             clear,
  input  logic [TMR_W-1:0] load_val,
  output logic             active
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/beat_sequencer.sv
// Bar/beat sequencer: gates metronome triggers by run state, counts beats and bars, drives click envelope.
// Latency: trigger or button at edge N shows on outputs at N+1; no backpressure, pulses are never stalled.
module beat_sequencer
  import metronome_pkg::*;
#(
  parameter int MAX_BEATS     = DEF_MAX_BEATS,
  parameter int ACCENT_CYCLES = DEF_ACCENT_CYCLES,
  parameter int NORMAL_CYCLES = DEF_NORMAL_CYCLES,
  parameter int BAR_W         = 16,
  localparam int IDX_W        = $clog2(MAX_BEATS + 1),
  localparam int TMR_W        = $clog2(max_int(ACCENT_CYCLES, NORMAL_CYCLES) + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_trigger,
  input  logic             i_btn_start_stop,
  input  logic             i_btn_beats_up,
  input  logic             i_btn_beats_down,
  output logic [IDX_W-1:0] o_beats_per_bar,
  output logic [IDX_W-1:0] o_beat_index,
  output logic [BAR_W-1:0] o_bar_count,
  output logic             o_running,
  output logic             o_click,
  output logic             o_accent,
  output logic             o_bar_start
);

  seq_state_t       state_q, state_d;
  logic             issue;
  logic             stop_evt;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   idx_inc;
  logic [IDX_W-1:0] bpb_q;
  logic [BAR_W-1:0] bar_q;
  logic             bar_start_q;
  logic             accent_q;
  logic             click_active;
  logic [TMR_W-1:0] tmr_load_val;

  // One bit wider so idx+1 never wraps before the >= comparison.
  assign idx_inc = {1'b0, idx_q} + (IDX_W + 1)'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    stop_evt = 1'b0;
    idx_d    = idx_q;
    case (state_q)
      STOPPED: begin
        if (i_btn_start_stop) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (i_btn_start_stop) begin
          state_d  = STOPPED;
          stop_evt = 1'b1;
        end else if (i_trigger) begin
          state_d = RUNNING;
          issue   = 1'b1;
          idx_d   = '0;
        end
      end
      RUNNING: begin
        if (i_btn_start_stop) begin
          state_d  = STOPPED;
          stop_evt = 1'b1;
        end else if (i_trigger) begin
          issue = 1'b1;
          // A bar shrunk below the current index wraps on the next beat.
          idx_d = (idx_inc >= {1'b0, bpb_q}) ? '0 : idx_inc[IDX_W-1:0];
        end
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idx_q       <= '0;
      bar_q       <= '0;
      bar_start_q <= 1'b0;
      accent_q    <= 1'b0;
    end else begin
      bar_start_q <= issue && (idx_d == '0);
      if (stop_evt) begin
        idx_q    <= '0;
        accent_q <= 1'b0;
      end else if (issue) begin
        idx_q    <= idx_d;
        accent_q <= (idx_d == '0);
        if (idx_d == '0) begin
          bar_q <= bar_q + BAR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bpb_q <= IDX_W'(DEF_BEATS_PER_BAR);
    end else if (i_btn_beats_up && !i_btn_beats_down && (bpb_q < IDX_W'(MAX_BEATS))) begin
      bpb_q <= bpb_q + IDX_W'(1);
    end else if (i_btn_beats_down && !i_btn_beats_up && (bpb_q > IDX_W'(1))) begin
      bpb_q <= bpb_q - IDX_W'(1);
    end
  end

  assign tmr_load_val = (idx_d == '0) ? TMR_W'(ACCENT_CYCLES) : TMR_W'(NORMAL_CYCLES);

  click_timer #(
    .TMR_W (TMR_W)
  ) u_click_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .load     (issue),
    .clear    (stop_evt),
    .load_val (tmr_load_val),
    .active   (click_active)
  );

  assign o_beats_per_bar = bpb_q;
  assign o_beat_index    = idx_q;
  assign o_bar_count     = bar_q;
  assign o_running       = (state_q != STOPPED);
  assign o_click         = click_active;
  assign o_accent        = accent_q & click_active;
  assign o_bar_start     = bar_start_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with short click lengths (accent 8, normal 4).
// Expected clicks are queued by the stimulus and matched by a negedge monitor.
module tb_beat_sequencer;

  localparam int MAX_BEATS = 16;
  localparam int ACC_L     = 8;
  localparam int NRM_L     = 4;
  localparam int BAR_W     = 16;
  localparam int IDX_W     = $clog2(MAX_BEATS + 1);

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_trigger;
  logic             i_btn_start_stop;
  logic             i_btn_beats_up;
  logic             i_btn_beats_down;
  logic [IDX_W-1:0] o_beats_per_bar;
  logic [IDX_W-1:0] o_beat_index;
  logic [BAR_W-1:0] o_bar_count;
  logic             o_running;
  logic             o_click;
  logic             o_accent;
  logic             o_bar_start;

  beat_sequencer #(
    .MAX_BEATS     (MAX_BEATS),
    .ACCENT_CYCLES (ACC_L),
    .NORMAL_CYCLES (NRM_L),
    .BAR_W         (BAR_W)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_trigger        (i_trigger),
    .i_btn_start_stop (i_btn_start_stop),
    .i_btn_beats_up   (i_btn_beats_up),
    .i_btn_beats_down (i_btn_beats_down),
    .o_beats_per_bar  (o_beats_per_bar),
    .o_beat_index     (o_beat_index),
    .o_bar_count      (o_bar_count),
    .o_running        (o_running),
    .o_click          (o_click),
    .o_accent         (o_accent),
    .o_bar_start      (o_bar_start)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int idx;
    int acc;
    int bs;
    int width;
  } click_t;

  click_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_click(input int idx, input int acc, input int bs, input int width);
    click_t c;
    c.idx = idx; c.acc = acc; c.bs = bs; c.width = width;
    exp_q.push_back(c);
  endtask

  // Every helper starts and ends 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_trig();
    i_trigger = 1'b1; tick(1); i_trigger = 1'b0;
  endtask

  task automatic pulse_ss();
    i_btn_start_stop = 1'b1; tick(1); i_btn_start_stop = 1'b0;
  endtask

  task automatic hold_up(input int n);
    i_btn_beats_up = 1'b1; tick(n); i_btn_beats_up = 1'b0;
  endtask

  task automatic hold_down(input int n);
    i_btn_beats_down = 1'b1; tick(n); i_btn_beats_down = 1'b0;
  endtask

  // Monitor: measures each click from its rising edge to its falling edge.
  bit     in_click = 1'b0;
  click_t cur;
  always @(negedge i_clk) begin
    if (i_reset) begin
      in_click = 1'b0;
    end else if (o_click && !in_click) begin
      in_click  = 1'b1;
      cur.idx   = int'(o_beat_index);
      cur.acc   = int'(o_accent);
      cur.bs    = int'(o_bar_start);
      cur.width = 1;
    end else if (o_click) begin
      cur.width++;
    end else if (in_click) begin
      in_click = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_click: got click idx %0d width %0d, expected none", cur.idx, cur.width);
      end else begin
        click_t e;
        e = exp_q.pop_front();
        chk("click_idx",       cur.idx,   e.idx);
        chk("click_accent",    cur.acc,   e.acc);
        chk("click_bar_start", cur.bs,    e.bs);
        chk("click_width",     cur.width, e.width);
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_trigger = 1'b0; i_btn_start_stop = 1'b0;
    i_btn_beats_up = 1'b0; i_btn_beats_down = 1'b0;
    tick(2);
    chk("rst_bpb", int'(o_beats_per_bar), 4);
    chk("rst_idx", int'(o_beat_index), 0);
    chk("rst_bar_count", int'(o_bar_count), 0);
    chk("rst_outs", int'({o_running, o_click, o_accent, o_bar_start}), 0);
    i_reset = 1'b0;
    tick(1);

    // Basic bar of 4 plus one more beat, then stop mid-bar.
    pulse_ss();
    chk("armed_running", int'(o_running), 1);
    for (int k = 0; k < 6; k++) begin
      case (k)
        0, 4:    expect_click(0, 1, 1, ACC_L);
        default: expect_click(k % 4, 0, 0, NRM_L);
      endcase
      pulse_trig();
      tick(19);
    end
    chk("bar_count_after_bar", int'(o_bar_count), 2);
    chk("idx_before_stop", int'(o_beat_index), 1);
    pulse_ss();
    chk("stop_running", int'(o_running), 0);
    chk("stop_idx", int'(o_beat_index), 0);
    chk("stop_holds_bar_count", int'(o_bar_count), 2);

    // Triggers while stopped are ignored.
    for (int k = 0; k < 3; k++) begin
      pulse_trig();
      chk("stopped_no_click", int'(o_click), 0);
      chk("stopped_idx", int'(o_beat_index), 0);
      tick(5);
    end

    // start_stop with trigger from STOPPED: arms only.
    i_btn_start_stop = 1'b1; i_trigger = 1'b1;
    tick(1);
    i_btn_start_stop = 1'b0; i_trigger = 1'b0;
    chk("ss_trig_arms", int'(o_running), 1);
    chk("ss_trig_no_click", int'(o_click), 0);
    tick(5);

    // Accent click cut after 3 cycles by start_stop with trigger while running.
    expect_click(0, 1, 1, 3);
    pulse_trig();
    tick(2);
    i_btn_start_stop = 1'b1; i_trigger = 1'b1;
    tick(1);
    i_btn_start_stop = 1'b0; i_trigger = 1'b0;
    chk("cut_running", int'(o_running), 0);
    chk("cut_click", int'(o_click), 0);
    chk("cut_idx", int'(o_beat_index), 0);
    chk("cut_bar_count", int'(o_bar_count), 3);
    tick(10);

    // Beats-per-bar saturation and simultaneous up/down.
    hold_up(20);
    chk("bpb_sat_max", int'(o_beats_per_bar), 16);
    i_btn_beats_down = 1'b1; hold_up(1); i_btn_beats_down = 1'b0;
    chk("bpb_both_at_max", int'(o_beats_per_bar), 16);
    hold_down(20);
    chk("bpb_sat_min", int'(o_beats_per_bar), 1);
    hold_up(2);
    chk("bpb_up2", int'(o_beats_per_bar), 3);
    i_btn_beats_down = 1'b1; hold_up(1); i_btn_beats_down = 1'b0;
    chk("bpb_both_mid", int'(o_beats_per_bar), 3);
    hold_down(2);
    chk("bpb_back_to_1", int'(o_beats_per_bar), 1);

    // bpb=1: every beat is an accent and a bar start.
    pulse_ss();
    for (int k = 0; k < 3; k++) begin
      expect_click(0, 1, 1, ACC_L);
      pulse_trig();
      tick(11);
    end
    chk("bpb1_bar_count", int'(o_bar_count), 6);

    // Shrink bar below current index while running.
    hold_up(7);
    chk("bpb_8", int'(o_beats_per_bar), 8);
    for (int k = 1; k <= 5; k++) begin
      expect_click(k, 0, 0, NRM_L);
      pulse_trig();
      tick(7);
    end
    hold_down(5);
    chk("bpb_3", int'(o_beats_per_bar), 3);
    chk("idx_kept_after_shrink", int'(o_beat_index), 5);
    expect_click(0, 1, 1, ACC_L);
    pulse_trig();
    tick(11);
    chk("shrink_bar_count", int'(o_bar_count), 7);

    // Retrigger two cycles into a normal click.
    expect_click(1, 0, 0, 2 + NRM_L);
    pulse_trig();
    tick(1);
    pulse_trig();
    chk("retrig_idx", int'(o_beat_index), 2);
    tick(10);

    // Asynchronous reset in the middle of an accent click.
    pulse_trig();
    chk("pre_reset_click", int'(o_click), 1);
    chk("pre_reset_bar_count", int'(o_bar_count), 8);
    tick(2);
    i_reset = 1'b1;
    #1;
    chk("arst_outs", int'({o_running, o_click, o_accent, o_bar_start}), 0);
    chk("arst_idx", int'(o_beat_index), 0);
    chk("arst_bar_count", int'(o_bar_count), 0);
    chk("arst_bpb", int'(o_beats_per_bar), 4);
    tick(2);
    i_reset = 1'b0;
    tick(1);
    pulse_trig();
    chk("post_reset_no_click", int'(o_click), 0);
    chk("post_reset_running", int'(o_running), 0);

    tick(20);
    chk("clicks_outstanding", exp_q.size(), 0);
    chk("click_in_progress", int'(in_click), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
